ram_rr_ctrl: RTL and testbench

//  Round-robin access controller for the single-port 16x16 RAM (cs/we/oe strobes, shared tristate data bus).

---
 rtl/ram_ctrl_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/ram_rr_ctrl.sv | 119 +++++++++++
 tb/tb_ram_rr_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the round-robin RAM access controller.
package ram_ctrl_pkg;

   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_NUM_REQ    = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Index width for an N-entry one-hot; never below 1 bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after last_gnt, wrapping.
module rr_arbiter
   import ram_ctrl_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IW      = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last_gnt,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IW-1:0]      gnt_idx,
   output logic               gnt_any
);

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      // Offset NUM_REQ lands back on last_gnt, so a lone requester keeps winning.
      for (int k = 1; k <= NUM_REQ; k++) begin
         int idx;
         idx = (int'(last_gnt) + k) % NUM_REQ;
         if (!gnt_any && req[IW'(idx)]) begin
            gnt_any          = 1'b1;
            gnt[IW'(idx)]    = 1'b1;
            gnt_idx          = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/ram_rr_ctrl.sv
// Serialises NUM_REQ valid/ready command streams onto a single-port RAM,
// one IDLE/ACCESS/RESP round per operation, with round-robin arbitration.
module ram_rr_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_REQ    = DEF_NUM_REQ
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0]               req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic                             rsp_we,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   inout  wire  [DATA_WIDTH-1:0]            mem_data,
   output logic                             mem_cs,
   output logic                             mem_we,
   output logic                             mem_oe
);

   localparam int IW = idx_w(NUM_REQ);

   state_t                state, state_n;
   logic [IW-1:0]         last_gnt, cur_gnt, gnt_idx;
   logic [NUM_REQ-1:0]    gnt;
   logic                  gnt_any;
   logic                  we_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
      .req      (req_valid),
      .last_gnt (last_gnt),
      .gnt      (gnt),
      .gnt_idx  (gnt_idx),
      .gnt_any  (gnt_any)
   );

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_we    = req_we[i];
            sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            req_ready = gnt;
            if (gnt_any) state_n = ACCESS;
         end
         ACCESS:  state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Strobes are loaded on the grant edge so they are glitch-free for all of ACCESS.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt  <= IW'(NUM_REQ-1);
         cur_gnt   <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         mem_addr  <= '0;
         mem_cs    <= 1'b0;
         mem_we    <= 1'b0;
         mem_oe    <= 1'b0;
         rsp_valid <= '0;
         rsp_we    <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         mem_cs    <= 1'b0;
         mem_we    <= 1'b0;
         mem_oe    <= 1'b0;
         rsp_valid <= '0;
         if (state == IDLE && gnt_any) begin
            last_gnt <= gnt_idx;
            cur_gnt  <= gnt_idx;
            we_q     <= sel_we;
            wdata_q  <= sel_wdata;
            mem_addr <= sel_addr;
            mem_cs   <= 1'b1;
            mem_we   <= sel_we;
            mem_oe   <= !sel_we;
         end
         if (state == ACCESS) begin
            if (!we_q) rsp_rdata <= mem_data;
            rsp_valid[cur_gnt] <= 1'b1;
            rsp_we             <= we_q;
         end
      end
   end

   // Bus is only ours during a write ACCESS; RESP and IDLE give read turnaround.
   assign mem_data = (mem_cs && mem_we) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_rr_ctrl.sv
// Bench: ram_rr_ctrl driving a 16x16 RAM model, checked by a scoreboard fed
// from a reference arbitration/memory model.
module tb_ram_rr_ctrl;

   localparam int AW = 4;
   localparam int DW = 16;
   localparam int N  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic            rsp_we;
   logic [DW-1:0]   rsp_rdata;
   logic [AW-1:0]   mem_addr;
   wire  [DW-1:0]   mem_data;
   logic            mem_cs, mem_we, mem_oe;

   logic          v_in [N];
   logic          w_in [N];
   logic [AW-1:0] a_in [N];
   logic [DW-1:0] d_in [N];

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign req_valid[g]          = v_in[g];
      assign req_we[g]             = w_in[g];
      assign req_addr[g*AW +: AW]  = a_in[g];
      assign req_wdata[g*DW +: DW] = d_in[g];
   end

   ram_rr_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
      .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
   );

   // RAM model: reads latch on negedge and drive the bus, writes on posedge.
   logic [DW-1:0] ram [16];
   logic [DW-1:0] ram_q = '0;
   logic          ram_drv = 1'b0;
   always @(negedge clk) begin
      ram_drv <= mem_cs && mem_oe && !mem_we;
      if (mem_cs && mem_oe && !mem_we) ram_q <= ram[mem_addr];
   end
   always @(posedge clk) if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
   assign mem_data = ram_drv ? ram_q : {DW{1'bz}};

   typedef struct {
      int            rq;
      logic          we;
      logic [DW-1:0] rdata;
      int            cyc;
   } exp_t;

   exp_t          sb [$];
   logic [DW-1:0] ref_mem [16];
   int            ref_last = N-1;
   int            busy_until = 0;
   int            acc_cyc = -1;
   logic          acc_we = 1'b0;
   logic [AW-1:0] acc_addr = '0;
   logic [DW-1:0] acc_wd = '0;
   logic [DW-1:0] last_rd = '0;
   logic          prev_rst = 1'b0;
   logic          started = 1'b0;
   int            cyc = 0;
   int            hs_req [$];
   int            hs_cyc [$];
   int            ready1_pulses = 0;
   int            errs = 0;
   int            checks = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model + monitor, evaluated mid-cycle.
   always @(negedge clk) begin
      exp_t          e;
      int            win;
      int            idx;
      logic [N-1:0]  exp_rdy;
      if (started && prev_rst) begin
         check("rst_rsp_valid", 32'(rsp_valid), 0);
         check("rst_rsp_we", 32'(rsp_we), 0);
         check("rst_rsp_rdata", 32'(rsp_rdata), 0);
         last_rd = '0;
      end
      if (rsp_valid != '0) begin
         if (sb.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 0);
         else begin
            e = sb.pop_front();
            check("rsp_who", 32'(rsp_valid), 32'(1 << e.rq));
            check("rsp_cycle", cyc, e.cyc);
            check("rsp_we", 32'(rsp_we), 32'(e.we));
            if (!e.we) last_rd = e.rdata;
            check("rsp_rdata", 32'(rsp_rdata), 32'(last_rd));
         end
      end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
         check("rsp_missing", cyc, sb[0].cyc);
         void'(sb.pop_front());
      end
      if (started) begin
         if (cyc == acc_cyc) begin
            check("acc_cs", 32'(mem_cs), 1);
            check("acc_we", 32'(mem_we), 32'(acc_we));
            check("acc_oe", 32'(mem_oe), 32'(!acc_we));
            check("acc_addr", 32'(mem_addr), 32'(acc_addr));
            if (acc_we) check("acc_wdata", 32'(mem_data), 32'(acc_wd));
         end else begin
            check("idle_strobes", {29'd0, mem_cs, mem_we, mem_oe}, 0);
         end
      end
      if (rst) begin
         sb.delete();
         busy_until = cyc + 1;
         ref_last   = N-1;
         acc_cyc    = -1;
      end else if (started) begin
         exp_rdy = '0;
         win     = -1;
         if (cyc >= busy_until)
            for (int k = 1; k <= N; k++) begin
               idx = (ref_last + k) % N;
               if (win < 0 && req_valid[idx]) win = idx;
            end
         if (win >= 0) exp_rdy[win] = 1'b1;
         check("req_ready", 32'(req_ready), 32'(exp_rdy));
         if (req_ready[1]) ready1_pulses++;
         if (win >= 0) begin
            ref_last   = win;
            busy_until = cyc + 3;
            acc_cyc    = cyc + 1;
            acc_we     = req_we[win];
            acc_addr   = req_addr[win*AW +: AW];
            acc_wd     = req_wdata[win*DW +: DW];
            if (acc_we) ref_mem[acc_addr] = acc_wd;
            e.rq    = win;
            e.we    = acc_we;
            e.rdata = acc_we ? '0 : ref_mem[acc_addr];
            e.cyc   = cyc + 2;
            sb.push_back(e);
            hs_req.push_back(win);
            hs_cyc.push_back(cyc);
         end
      end
      prev_rst = rst;
      if (rst) started = 1'b1;
   end

   task automatic do_op(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      logic got;
      got = 1'b0;
      v_in[i] = 1'b1; w_in[i] = we; a_in[i] = a; d_in[i] = d;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (req_ready[i]) begin got = 1'b1; break; end
      end
      if (!got) check("hs_timeout", 0, 1);
      @(posedge clk); #1;
      v_in[i] = 1'b0;
   endtask

   task automatic wait_rsp(input int i, input logic [DW-1:0] exp, input string nm);
      @(posedge clk); #1;
      check({nm, "_valid"}, 32'(rsp_valid[i]), 1);
      check({nm, "_data"}, 32'(rsp_rdata), 32'(exp));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic rand_stream(input int i, input int n);
      int g;
      for (int k = 0; k < n; k++) begin
         g = int'($urandom_range(0, 3));
         if (g > 0) begin repeat (g) @(posedge clk); #1; end
         do_op(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));
      end
   endtask

   initial begin
      int base;
      int p1;
      logic got;
      for (int i = 0; i < N; i++) begin
         v_in[i] = 1'b0; w_in[i] = 1'b0; a_in[i] = '0; d_in[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // 1: write then read back, latency checked by scoreboard
      do_op(0, 1'b1, 4'd3, 16'hA5A5);
      @(posedge clk); #1;
      do_op(0, 1'b0, 4'd3, 16'h0);
      wait_rsp(0, 16'hA5A5, "t1_read");
      check("t1_rsp_we", 32'(rsp_we), 0);

      // 2: simultaneous requesters alternate from reset
      do_reset();
      base = hs_req.size();
      fork
         begin do_op(0, 1'b1, 4'd1, 16'h1111); do_op(0, 1'b1, 4'd1, 16'h1111); end
         begin do_op(1, 1'b1, 4'd2, 16'h2222); do_op(1, 1'b1, 4'd2, 16'h2222); end
      join
      check("t2_gnt0", hs_req[base],   0);
      check("t2_gnt1", hs_req[base+1], 1);
      check("t2_gnt2", hs_req[base+2], 0);
      check("t2_gnt3", hs_req[base+3], 1);
      repeat (3) @(posedge clk); #1;

      // 4: fill every address, read all back (15 -> 0 wrap is just the next op)
      for (int a = 0; a < 16; a++) do_op(1, 1'b1, 4'(a), 16'(a) * 16'h0101);
      for (int a = 15; a >= 0; a--) begin
         do_op(1, 1'b0, 4'(a), 16'h0);
         wait_rsp(1, 16'(a) * 16'h0101, "t4_read");
      end
      do_op(0, 1'b0, 4'd0, 16'h0);
      wait_rsp(0, 16'h0000, "t4_addr0");

      // 3: read immediately followed by write to the same address
      base = hs_cyc.size();
      do_op(0, 1'b0, 4'd5, 16'h0);
      do_op(0, 1'b1, 4'd5, 16'hBEEF);
      check("t3_turnaround", 32'(hs_cyc[base+1] - hs_cyc[base] >= 3), 1);
      @(posedge clk); #1;
      do_op(0, 1'b0, 4'd5, 16'h0);
      wait_rsp(0, 16'hBEEF, "t3_readback");

      // 5: reset lands during a write ACCESS
      @(posedge clk); #1;
      do_op(0, 1'b1, 4'd7, 16'h1234);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("t5_cs_after_rst", 32'(mem_cs), 0);
      check("t5_rsp_after_rst", 32'(rsp_valid), 0);
      @(posedge clk); #1;
      check("t5_no_rsp", 32'(rsp_valid), 0);
      do_op(0, 1'b0, 4'd7, 16'h0);
      wait_rsp(0, 16'h1234, "t5_readback");

      // 6: req1 pulses valid only while req0 is busy; req0 streams at full rate
      @(posedge clk); #1;
      base = hs_cyc.size();
      p1   = ready1_pulses;
      fork
         for (int k = 0; k < 4; k++) do_op(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));
         for (int k = 0; k < 2; k++) begin
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
               @(negedge clk);
               got = req_valid[0] && req_ready[0];
            end
            @(posedge clk); #1 v_in[1] = 1'b1;
            @(posedge clk); #1 v_in[1] = 1'b0;
         end
      join
      check("t6_ready1_pulses", ready1_pulses - p1, 0);
      for (int k = 1; k < 4; k++) check("t6_rate", hs_cyc[base+k] - hs_cyc[base+k-1], 3);

      // 7: randomized traffic from both requesters
      repeat (3) @(posedge clk); #1;
      fork
         rand_stream(0, 25);
         rand_stream(1, 25);
      join

      repeat (8) @(posedge clk); #1;
      check("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
